// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - load/store codes, FSM state type and decode helpers for lsu_mem_ctrl
package lsu_pkg;
    localparam logic [2:0] LD_B  = 3'b000;
    localparam logic [2:0] LD_H  = 3'b001;
    localparam logic [2:0] LD_W  = 3'b010;
    localparam logic [2:0] LD_BU = 3'b011;
    localparam logic [2:0] LD_HU = 3'b100;

    localparam logic [1:0] ST_B = 2'b00;
    localparam logic [1:0] ST_H = 2'b01;
    localparam logic [1:0] ST_W = 2'b10;

    // Size codes deliberately share the store_type encoding.
    localparam logic [1:0] SZ_1 = 2'b00;
    localparam logic [1:0] SZ_2 = 2'b01;
    localparam logic [1:0] SZ_4 = 2'b10;

    typedef enum logic [1:0] {S_IDLE, S_ACC1, S_ACC2, S_DONE} state_t;

    function automatic logic [3:0] sizemask(input logic [1:0] sz);
        logic [3:0] m;
        case (sz)
            SZ_1:    m = 4'h1;
            SZ_2:    m = 4'h3;
            default: m = 4'hF;
        endcase
        return m;
    endfunction

    function automatic logic [1:0] load_size(input logic [2:0] lt);
        logic [1:0] sz;
        case (lt)
            LD_B, LD_BU: sz = SZ_1;
            LD_H, LD_HU: sz = SZ_2;
            default:     sz = SZ_4;
        endcase
        return sz;
    endfunction

    function automatic logic is_legal(input logic rd, input logic wr,
                                      input logic [2:0] lt, input logic [1:0] st);
        logic ok;
        ok = 1'b0;
        if (rd && !wr)
            ok = (lt <= LD_HU);
        else if (wr && !rd)
            ok = (st != 2'b11);
        return ok;
    endfunction
endpackage

// File: rtl/lsu_load_extend.sv
// rtl/lsu_load_extend.sv - truncates a merged load word to its size and sign/zero-extends it
module lsu_load_extend
    import lsu_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  size,
    input  logic        is_signed,
    output logic [31:0] result
);
    always_comb begin
        case (size)
            SZ_1:    result = {{24{is_signed & word[7]}}, word[7:0]};
            SZ_2:    result = {{16{is_signed & word[15]}}, word[15:0]};
            default: result = word;
        endcase
    end
endmodule

// File: rtl/lsu_mem_ctrl.sv
// rtl/lsu_mem_ctrl.sv - load/store unit: splits misaligned accesses into word beats and stalls the pipe
module lsu_mem_ctrl
    import lsu_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [2:0]        load_type,
    input  logic [1:0]        store_type,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    output logic              stall,
    output logic              done,
    output logic              err,
    output logic [31:0]       rdata,
    output logic              bus_valid,
    input  logic              bus_ready,
    output logic              bus_we,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [3:0]        bus_be,
    output logic [31:0]       bus_wdata,
    input  logic [31:0]       bus_rdata
);
    state_t state, state_nx;
    logic accept, reject, split;
    logic is_load_q, signed_q;
    logic [1:0] size_q, off_q;
    logic [ADDR_W-1:0] base_q;
    logic [31:0] wdata_q, lo_q, hi_w, lo_w, wdata_rot, merged, load_result;
    logic [7:0] mask8;

    assign mask8 = {4'b0000, sizemask(size_q)} << off_q;
    assign split = |mask8[7:4];
    assign done  = (state == S_DONE);
    assign stall = req_valid & (mem_read | mem_write) & ~done & ~err;

    always_comb begin
        case (addr[1:0])
            2'd0:    wdata_rot = wdata;
            2'd1:    wdata_rot = {wdata[23:0], wdata[31:24]};
            2'd2:    wdata_rot = {wdata[15:0], wdata[31:16]};
            default: wdata_rot = {wdata[7:0],  wdata[31:8]};
        endcase
    end

    // A single-beat load merges its word with itself; only the low bytes survive truncation.
    assign lo_w = (state == S_ACC2) ? lo_q : bus_rdata;
    assign hi_w = bus_rdata;

    always_comb begin
        case (off_q)
            2'd0:    merged = lo_w;
            2'd1:    merged = {hi_w[7:0],  lo_w[31:8]};
            2'd2:    merged = {hi_w[15:0], lo_w[31:16]};
            default: merged = {hi_w[23:0], lo_w[31:24]};
        endcase
    end

    lsu_load_extend u_extend (
        .word      (merged),
        .size      (size_q),
        .is_signed (signed_q),
        .result    (load_result)
    );

    // err blocks acceptance for a cycle so a rejected request is not re-evaluated.
    always_comb begin
        state_nx = state;
        accept   = 1'b0;
        reject   = 1'b0;
        case (state)
            S_IDLE: begin
                if (req_valid && !err && (mem_read || mem_write)) begin
                    if (is_legal(mem_read, mem_write, load_type, store_type)) begin
                        accept   = 1'b1;
                        state_nx = S_ACC1;
                    end else begin
                        reject = 1'b1;
                    end
                end
            end
            S_ACC1:  if (bus_valid && bus_ready) state_nx = split ? S_ACC2 : S_DONE;
            S_ACC2:  if (bus_valid && bus_ready) state_nx = S_DONE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nx;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus_valid <= 1'b0;
            err       <= 1'b0;
            rdata     <= 32'b0;
            is_load_q <= 1'b0;
            signed_q  <= 1'b0;
            size_q    <= SZ_1;
            off_q     <= 2'b00;
            base_q    <= '0;
            wdata_q   <= 32'b0;
            lo_q      <= 32'b0;
        end else begin
            bus_valid <= (state_nx == S_ACC1) || (state_nx == S_ACC2);
            err       <= reject;
            if (accept) begin
                is_load_q <= mem_read;
                signed_q  <= (load_type == LD_B) || (load_type == LD_H);
                size_q    <= mem_read ? load_size(load_type) : store_type;
                off_q     <= addr[1:0];
                base_q    <= {addr[ADDR_W-1:2], 2'b00};
                wdata_q   <= wdata_rot;
            end
            if (state == S_ACC1 && bus_valid && bus_ready)
                lo_q <= bus_rdata;
            if (is_load_q && state_nx == S_DONE)
                rdata <= load_result;
        end
    end

    always_comb begin
        bus_addr  = '0;
        bus_be    = 4'b0000;
        bus_wdata = 32'b0;
        bus_we    = 1'b0;
        if (bus_valid) begin
            bus_we    = ~is_load_q;
            bus_wdata = wdata_q;
            if (state == S_ACC2) begin
                bus_addr = base_q + ADDR_W'(4);
                bus_be   = mask8[7:4];
            end else begin
                bus_addr = base_q;
                bus_be   = mask8[3:0];
            end
        end
    end
endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// tb/tb_lsu_mem_ctrl.sv - directed and randomized checks of lsu_mem_ctrl against a byte-addressed memory model
`timescale 1ns/1ps
module tb_lsu_mem_ctrl;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0, mem_read = 1'b0, mem_write = 1'b0;
    logic [2:0]  load_type = 3'b0;
    logic [1:0]  store_type = 2'b0;
    logic [31:0] addr = 32'b0, wdata = 32'b0;
    logic        stall, done, err, bus_valid, bus_we;
    logic [31:0] rdata, bus_addr, bus_wdata;
    logic [3:0]  bus_be;
    logic        bus_ready = 1'b0;
    logic [31:0] bus_rdata = 32'b0;

    int ntests = 0;
    int nfail  = 0;
    int wait_n = 0;
    int wcnt   = 0;
    logic [31:0] last_load = 32'b0;

    logic [7:0] mem [logic [31:0]];
    typedef struct {
        logic [31:0] a;
        logic [3:0]  be;
        logic [31:0] wd;
        logic        we;
    } beat_t;
    beat_t beats[$];

    always #5 clk = ~clk;

    lsu_mem_ctrl #(.ADDR_W(32)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .mem_read(mem_read),
        .mem_write(mem_write), .load_type(load_type), .store_type(store_type),
        .addr(addr), .wdata(wdata), .stall(stall), .done(done), .err(err),
        .rdata(rdata), .bus_valid(bus_valid), .bus_ready(bus_ready), .bus_we(bus_we),
        .bus_addr(bus_addr), .bus_be(bus_be), .bus_wdata(bus_wdata), .bus_rdata(bus_rdata)
    );

    function automatic logic [7:0] rd_byte(input logic [31:0] a);
        if (mem.exists(a)) return mem[a];
        return a[7:0] ^ a[15:8] ^ 8'hA5;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ntests++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic set_word(input logic [31:0] a, input logic [31:0] w);
        for (int i = 0; i < 4; i++) mem[a + 32'(i)] = w[8*i +: 8];
    endtask

    // Bus slave: fixed wait states per beat, random ready while idle, byte-lane writes.
    always @(negedge clk) begin
        if (bus_valid) begin
            if (wcnt >= wait_n) begin
                bus_ready = 1'b1;
                bus_rdata = {rd_byte(bus_addr + 32'd3), rd_byte(bus_addr + 32'd2),
                             rd_byte(bus_addr + 32'd1), rd_byte(bus_addr)};
                beats.push_back('{bus_addr, bus_be, bus_wdata, bus_we});
                if (bus_we)
                    for (int l = 0; l < 4; l++)
                        if (bus_be[l]) mem[bus_addr + 32'(l)] = bus_wdata[8*l +: 8];
                wcnt = 0;
            end else begin
                bus_ready = 1'b0;
                wcnt++;
            end
        end else begin
            bus_ready = 1'($urandom_range(0, 1));
            bus_rdata = $urandom;
            wcnt = 0;
            chk("idle_be_we", {27'b0, bus_we, bus_be}, 32'b0);
            chk("idle_wdata", bus_wdata, 32'b0);
        end
    end

    task automatic access(input logic is_ld, input logic [2:0] lt, input logic [1:0] st,
                          input logic [31:0] a, input logic [31:0] wd, input int waits,
                          input string tag);
        int size, cycles, nexp, idx;
        logic [31:0] exp_a [2];
        logic [3:0]  exp_be [2];
        logic [31:0] val, exp_wd, b;
        if (is_ld) size = (lt == 3'd0 || lt == 3'd3) ? 1 : (lt == 3'd2) ? 4 : 2;
        else       size = (st == 2'd0) ? 1 : (st == 2'd1) ? 2 : 4;
        nexp = 0;
        val  = 32'b0;
        for (int i = 0; i < size; i++) begin
            b = a + 32'(i);
            if (nexp == 0 || exp_a[nexp-1] != {b[31:2], 2'b00}) begin
                exp_a[nexp]  = {b[31:2], 2'b00};
                exp_be[nexp] = 4'b0;
                nexp++;
            end
            exp_be[nexp-1][b[1:0]] = 1'b1;
            val[8*i +: 8] = rd_byte(b);
        end
        for (int l = 0; l < 4; l++) begin
            idx = (l + 4 - int'(a[1:0])) % 4;
            exp_wd[8*l +: 8] = wd[8*idx +: 8];
        end
        case (lt)
            3'd0:    val = {{24{val[7]}}, val[7:0]};
            3'd1:    val = {{16{val[15]}}, val[15:0]};
            default: val = val;
        endcase

        wait_n = waits;
        beats.delete();
        @(negedge clk);
        req_valid = 1'b1; mem_read = is_ld; mem_write = !is_ld;
        load_type = lt; store_type = st; addr = a; wdata = wd;
        cycles = 0;
        #1;
        while (stall && cycles < 300) begin
            cycles++;
            @(negedge clk);
            #1;
        end
        chk({tag, "_done"}, {31'b0, done}, 32'd1);
        chk({tag, "_stall_cycles"}, 32'(cycles), 32'(1 + nexp * (waits + 1)));
        chk({tag, "_beats"}, 32'(beats.size()), 32'(nexp));
        for (int k = 0; k < nexp && k < beats.size(); k++) begin
            chk({tag, "_beat_addr"}, beats[k].a, exp_a[k]);
            chk({tag, "_beat_be"}, {28'b0, beats[k].be}, {28'b0, exp_be[k]});
            chk({tag, "_beat_we"}, {31'b0, beats[k].we}, {31'b0, !is_ld});
            if (!is_ld) chk({tag, "_beat_wdata"}, beats[k].wd, exp_wd);
        end
        if (is_ld) last_load = val;
        chk({tag, "_rdata"}, rdata, last_load);
        if (!is_ld)
            for (int i = 0; i < size; i++)
                chk({tag, "_mem"}, {24'b0, rd_byte(a + 32'(i))}, {24'b0, wd[8*i +: 8]});
        req_valid = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
    endtask

    task automatic bad_req(input logic rd, input logic wr, input logic [2:0] lt,
                           input logic [1:0] st, input string tag);
        beats.delete();
        wait_n = 0;
        @(negedge clk);
        req_valid = 1'b1; mem_read = rd; mem_write = wr; load_type = lt; store_type = st;
        addr = 32'h0000_0120;
        #1;
        chk({tag, "_stall_req"}, {31'b0, stall}, 32'd1);
        @(negedge clk);
        #1;
        chk({tag, "_err"}, {31'b0, err}, 32'd1);
        chk({tag, "_stall_err"}, {31'b0, stall}, 32'd0);
        chk({tag, "_done"}, {31'b0, done}, 32'd0);
        req_valid = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
        @(negedge clk);
        #1;
        chk({tag, "_err_pulse"}, {31'b0, err}, 32'd0);
        repeat (2) @(negedge clk);
        #1;
        chk({tag, "_no_bus"}, 32'(beats.size()), 32'd0);
        chk({tag, "_no_done"}, {31'b0, done}, 32'd0);
    endtask

    initial begin
        int cyc;
        logic        r_ld;
        logic [31:0] r_a;

        // Reset values and the combinational stall equation
        repeat (2) @(negedge clk);
        req_valid = 1'b1; mem_read = 1'b1;
        #1;
        chk("rst_stall_eq", {31'b0, stall}, 32'd1);
        chk("rst_bus_valid", {31'b0, bus_valid}, 32'd0);
        chk("rst_done_err", {30'b0, done, err}, 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        req_valid = 1'b0; mem_read = 1'b0;
        #1;
        chk("rst_stall_idle", {31'b0, stall}, 32'd0);
        @(negedge clk);
        reset = 1'b0;

        set_word(32'h100, 32'hDEADBEEF);
        access(1'b1, 3'd2, 2'd0, 32'h100, 32'h0, 0, "lw_aligned");
        chk("lw_aligned_const", rdata, 32'hDEADBEEF);

        set_word(32'h100, 32'h80FFFFFF);
        access(1'b1, 3'd0, 2'd0, 32'h103, 32'h0, 0, "lb_103");
        chk("lb_103_const", rdata, 32'hFFFFFF80);
        access(1'b1, 3'd3, 2'd0, 32'h103, 32'h0, 1, "lbu_103");
        chk("lbu_103_const", rdata, 32'h00000080);

        access(1'b0, 3'd0, 2'd1, 32'h203, 32'h0000_1234, 0, "sh_203");
        if (beats.size() > 0) chk("sh_203_wdata_const", beats[0].wd, 32'h34000012);

        set_word(32'h0, 32'h44332211);
        set_word(32'h4, 32'h88776655);
        access(1'b1, 3'd2, 2'd0, 32'h001, 32'h0, 3, "lw_split");
        chk("lw_split_const", rdata, 32'h55443322);

        access(1'b1, 3'd2, 2'd0, 32'hFFFF_FFFE, 32'h0, 0, "lw_wrap");
        access(1'b0, 3'd0, 2'd2, 32'hFFFF_FFFF, 32'hCAFE_F00D, 1, "sw_wrap");
        access(1'b1, 3'd1, 2'd0, 32'h0000_0307, 32'h0, 0, "lh_split");

        bad_req(1'b1, 1'b1, 3'd2, 2'd2, "both_set");
        bad_req(1'b1, 1'b0, 3'd5, 2'd0, "ld_type_101");
        bad_req(1'b1, 1'b0, 3'd7, 2'd0, "ld_type_111");
        bad_req(1'b0, 1'b1, 3'd0, 2'd3, "st_type_11");

        // Neither read nor write: no stall, no bus activity
        beats.delete();
        @(negedge clk);
        req_valid = 1'b1;
        #1;
        chk("ignored_stall", {31'b0, stall}, 32'd0);
        repeat (3) @(negedge clk);
        #1;
        chk("ignored_beats", 32'(beats.size()), 32'd0);
        chk("ignored_done_err", {30'b0, done, err}, 32'd0);
        req_valid = 1'b0;

        // Reset while the second beat of a split load is waiting
        beats.delete();
        wait_n = 0;
        @(negedge clk);
        req_valid = 1'b1; mem_read = 1'b1; load_type = 3'd2; addr = 32'h0000_0302;
        cyc = 0;
        #1;
        while (beats.size() == 0 && cyc < 20) begin
            @(negedge clk);
            #1;
            cyc++;
        end
        wait_n = 50;
        chk("rst_mid_beat1", 32'(beats.size()), 32'd1);
        @(negedge clk);
        #1;
        chk("rst_mid_acc2_valid", {31'b0, bus_valid}, 32'd1);
        chk("rst_mid_acc2_addr", bus_addr, 32'h0000_0304);
        reset = 1'b1;
        #1;
        chk("rst_mid_valid_drop", {31'b0, bus_valid}, 32'd0);
        chk("rst_mid_done", {31'b0, done}, 32'd0);
        chk("rst_mid_rdata", rdata, 32'd0);
        req_valid = 1'b0; mem_read = 1'b0;
        last_load = 32'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        wait_n = 0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_after_done", {31'b0, done}, 32'd0);
        chk("rst_after_rdata", rdata, 32'd0);
        set_word(32'h500, 32'h0BADC0DE);
        access(1'b1, 3'd2, 2'd0, 32'h500, 32'h0, 0, "lw_after_rst");

        // Randomized legal accesses
        for (int n = 0; n < 40; n++) begin
            r_ld = 1'($urandom_range(0, 1));
            r_a  = ($urandom_range(0, 9) == 0) ? 32'hFFFF_FFFC + 32'($urandom_range(0, 3))
                                              : 32'h400 + 32'($urandom_range(0, 63));
            access(r_ld, 3'($urandom_range(0, 4)), 2'($urandom_range(0, 2)), r_a,
                   $urandom, int'($urandom_range(0, 2)), "rand");
        end

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1);
    end
endmodule
